// File: rtl/ex_hilo_if.sv
// ex_hilo_if: EX-stage bundle between the pipeline and the HI/LO unit.
//   master : pipeline side, drives start/op/rs_val/rt_val/cancel and
//            observes hi/lo/busy/done.
//   slave  : HI/LO unit side.
//   start/op/rs_val/rt_val/cancel  op request and flush from EX.
//   hi/lo                          architectural HI/LO registers.
//   busy/done                      multiply/divide in flight / completion pulse.
interface ex_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             cancel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, rs_val, rt_val, cancel,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, rs_val, rt_val, cancel,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/ex_hilo_unit.sv
// ex_hilo_unit: HI/LO registers for the EX stage. MTHI/MTLO write in a
// single cycle; MULT/MULTU/DIV/DIVU run iteratively (one bit per cycle)
// on operand magnitudes, with sign correction applied in a final cycle.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  ex_hilo_if slave port (start, op, rs_val, rt_val, cancel in;
//        hi, lo, busy, done out)
//
// state | meaning
// IDLE  | no multiply/divide in flight; accepts new ops
// CALC  | one multiplier/quotient bit per cycle, counter WIDTH-1 down to 0
// FIX   | sign correction, HI/LO write, raise done
module ex_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  ex_hilo_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   a_q, a_d;          // multiplicand / dividend magnitude
  logic [WIDTH-1:0]   b_q, b_d;          // multiplier / divisor magnitude
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rs_raw_q, rs_raw_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;

  logic               accept;
  logic               signed_op;
  logic               is_muldiv;
  logic               op_is_div;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign accept    = (state_q == IDLE) && bus.start && !bus.cancel;
  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign op_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign is_muldiv = (bus.op == OP_MULT) || (bus.op == OP_MULTU) || op_is_div;

  // Restoring step: partial remainder is always below the divisor, so the
  // difference fits in WIDTH bits whenever the subtraction is taken.
  assign rem_shift = {rem_q, a_q[cnt_q]};
  assign rem_diff  = rem_shift[WIDTH-1:0] - b_q;

  // MSB-first shift-add: the counter selects the current multiplier bit.
  assign addend = b_q[cnt_q] ? {{WIDTH{1'b0}}, a_q} : '0;

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -quo_q : quo_q;
  assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    rs_raw_d  = rs_raw_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.op == OP_MTHI) begin
            hi_d = bus.rs_val;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.rs_val;
          end else if (is_muldiv) begin
            // -MIN wraps to MIN, which reads correctly as an unsigned magnitude.
            a_d       = (signed_op && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
            b_d       = (signed_op && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
            neg_res_d = signed_op && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
            neg_rem_d = signed_op && bus.rs_val[WIDTH-1];
            is_div_d  = op_is_div;
            dbz_d     = op_is_div && (bus.rt_val == '0);
            rs_raw_d  = bus.rs_val;
            acc_d     = '0;
            rem_d     = '0;
            quo_d     = '0;
            cnt_d     = CNT_W'(WIDTH - 1);
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            if (rem_shift >= {1'b0, b_q}) begin
              rem_d        = rem_diff;
              quo_d[cnt_q] = 1'b1;
            end else begin
              rem_d = rem_shift[WIDTH-1:0];
            end
          end else begin
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0} + addend;
          end
          if (cnt_q == '0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      FIX: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (dbz_q) begin
            hi_d = rs_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      rs_raw_q  <= '0;
      acc_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      rs_raw_q  <= rs_raw_d;
      acc_q     <= acc_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

endmodule
